lvds_panel_seq: RTL and testbench

Power-sequencing controller for an LVDS panel driven by `lvds_tx`. It enforces the panel datasheet order on power-up: VDD, then LVDS clock, then video, then backlight. Power-down runs in reverse order, with video start and stop aligned to frame boundaries. It runs in the `pclk` domain. Its outputs drive the panel supply switch, the `lvds_tx` reset and video gating, and the backlight enable.

---
 rtl/lvds_panel_seq_if.sv | 24 ++
 rtl/lvds_panel_seq.sv | 194 +++++++++++++++++++
 tb/tb_lvds_panel_seq.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lvds_panel_seq_if.sv
// Control and status bundle between the LVDS panel power sequencer and its host.
// The host drives the requests and vs; the sequencer drives the enables and status.
interface lvds_panel_seq_if;
    logic       power_req;
    logic       fault;
    logic       vs;
    logic       vdd_en;
    logic       lvds_en;
    logic       video_en;
    logic       bl_en;
    logic       ready;
    logic [2:0] state;
    logic       vs_timeout;

    modport master (
        output power_req, fault, vs,
        input  vdd_en, lvds_en, video_en, bl_en, ready, state, vs_timeout
    );

    modport slave (
        input  power_req, fault, vs,
        output vdd_en, lvds_en, video_en, bl_en, ready, state, vs_timeout
    );
endinterface

// File: rtl/lvds_panel_seq.sv
// LVDS panel power sequencer: VDD -> LVDS clock -> video -> backlight on the way up,
// the reverse on the way down, with video start/stop aligned to vs and a fault bail-out.
module lvds_panel_seq #(
    parameter int unsigned T_VDD     = 1000,
    parameter int unsigned T_CLK     = 1000,
    parameter int unsigned T_BL_ON   = 1000,
    parameter int unsigned T_BL_OFF  = 1000,
    parameter int unsigned T_VDD_OFF = 1000,
    parameter int unsigned T_OFF_MIN = 1000,
    parameter int unsigned VS_TO     = 65535,
    parameter bit          VS_POL    = 1'b1,
    parameter int unsigned CNT_W     = 20
) (
    input logic             pclk,
    input logic             rst_n,
    lvds_panel_seq_if.slave ctl
);

    typedef enum logic [2:0] {
        ST_OFF     = 3'd0,
        ST_VDD     = 3'd1,
        ST_CLK     = 3'd2,
        ST_VID     = 3'd3,
        ST_ON      = 3'd4,
        ST_DN_BL   = 3'd5,
        ST_DN_LVDS = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] LD_VDD     = CNT_W'(T_VDD - 1);
    localparam logic [CNT_W-1:0] LD_CLK     = CNT_W'(T_CLK - 1);
    localparam logic [CNT_W-1:0] LD_BL_ON   = CNT_W'(T_BL_ON - 1);
    localparam logic [CNT_W-1:0] LD_BL_OFF  = CNT_W'(T_BL_OFF - 1);
    localparam logic [CNT_W-1:0] LD_VDD_OFF = CNT_W'(T_VDD_OFF - 1);
    localparam logic [CNT_W-1:0] LD_OFF_MIN = CNT_W'(T_OFF_MIN - 1);
    localparam logic [CNT_W-1:0] LD_VS_TO   = CNT_W'(VS_TO - 1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             vs_wait_reg, vs_wait_next;
    logic             vs_timeout_reg, vs_timeout_next;

    logic             vs_q_reg, vs_q2_reg, vs_rise_reg;

    logic             vdd_en_reg, lvds_en_reg, video_en_reg, bl_en_reg, ready_reg;

    logic             cnt_zero;
    logic             vs_go;
    logic             vs_expire;

    // The edge pulse is itself registered, giving two cycles from pin edge to use.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q_reg    <= 1'b0;
            vs_q2_reg   <= 1'b0;
            vs_rise_reg <= 1'b0;
        end else begin
            vs_q_reg    <= ctl.vs;
            vs_q2_reg   <= vs_q_reg;
            vs_rise_reg <= VS_POL ? (vs_q_reg & ~vs_q2_reg) : (~vs_q_reg & vs_q2_reg);
        end
    end

    assign cnt_zero = (cnt_reg == '0);

    // Before the dwell ends an edge only counts on the expiry edge itself; once
    // waiting, either an edge or the timeout counter reaching zero lets us proceed.
    assign vs_go     = vs_wait_reg ? (vs_rise_reg | cnt_zero) : (cnt_zero & vs_rise_reg);
    assign vs_expire = vs_wait_reg & cnt_zero & ~vs_rise_reg;

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_zero ? cnt_reg : (cnt_reg - CNT_W'(1));
        vs_wait_next    = vs_wait_reg;
        vs_timeout_next = vs_timeout_reg;

        unique case (state_reg)
            ST_OFF: begin
                if (ctl.power_req && !ctl.fault && cnt_zero) begin
                    state_next      = ST_VDD;
                    cnt_next        = LD_VDD;
                    vs_timeout_next = 1'b0;
                end
            end
            ST_VDD: begin
                if (!ctl.power_req) begin
                    state_next = ST_OFF;
                    cnt_next   = LD_OFF_MIN;
                end else if (cnt_zero) begin
                    state_next = ST_CLK;
                    cnt_next   = LD_CLK;
                end
            end
            ST_CLK: begin
                if (!ctl.power_req) begin
                    state_next = ST_DN_LVDS;
                    cnt_next   = LD_VDD_OFF;
                end else if (vs_go) begin
                    state_next = ST_VID;
                    cnt_next   = LD_BL_ON;
                    if (vs_expire) begin
                        vs_timeout_next = 1'b1;
                    end
                end else if (cnt_zero && !vs_wait_reg) begin
                    vs_wait_next = 1'b1;
                    cnt_next     = LD_VS_TO;
                end
            end
            ST_VID: begin
                if (!ctl.power_req) begin
                    state_next = ST_DN_BL;
                    cnt_next   = LD_BL_OFF;
                end else if (cnt_zero) begin
                    state_next = ST_ON;
                end
            end
            ST_ON: begin
                if (!ctl.power_req) begin
                    state_next = ST_DN_BL;
                    cnt_next   = LD_BL_OFF;
                end
            end
            ST_DN_BL: begin
                if (vs_go) begin
                    state_next = ST_DN_LVDS;
                    cnt_next   = LD_VDD_OFF;
                    if (vs_expire) begin
                        vs_timeout_next = 1'b1;
                    end
                end else if (cnt_zero && !vs_wait_reg) begin
                    vs_wait_next = 1'b1;
                    cnt_next     = LD_VS_TO;
                end
            end
            ST_DN_LVDS: begin
                if (cnt_zero) begin
                    state_next = ST_OFF;
                    cnt_next   = LD_OFF_MIN;
                end
            end
            default: begin
                state_next = ST_OFF;
                cnt_next   = LD_OFF_MIN;
            end
        endcase

        // Fault overrides whatever the sequence wanted this edge.
        if (ctl.fault && (state_reg != ST_OFF)) begin
            state_next      = ST_OFF;
            cnt_next        = LD_OFF_MIN;
            vs_timeout_next = vs_timeout_reg;
        end

        if (state_next != state_reg) begin
            vs_wait_next = 1'b0;
        end
    end

    // Enables are decoded from the next state so they switch on the transition edge.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_OFF;
            cnt_reg        <= '0;
            vs_wait_reg    <= 1'b0;
            vs_timeout_reg <= 1'b0;
            vdd_en_reg     <= 1'b0;
            lvds_en_reg    <= 1'b0;
            video_en_reg   <= 1'b0;
            bl_en_reg      <= 1'b0;
            ready_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            vs_wait_reg    <= vs_wait_next;
            vs_timeout_reg <= vs_timeout_next;
            vdd_en_reg     <= (state_next != ST_OFF);
            lvds_en_reg    <= (state_next inside {ST_CLK, ST_VID, ST_ON, ST_DN_BL});
            video_en_reg   <= (state_next inside {ST_VID, ST_ON, ST_DN_BL});
            bl_en_reg      <= (state_next == ST_ON);
            ready_reg      <= (state_next == ST_ON);
        end
    end

    assign ctl.vdd_en     = vdd_en_reg;
    assign ctl.lvds_en    = lvds_en_reg;
    assign ctl.video_en   = video_en_reg;
    assign ctl.bl_en      = bl_en_reg;
    assign ctl.ready      = ready_reg;
    assign ctl.state      = state_reg;
    assign ctl.vs_timeout = vs_timeout_reg;

    a_enable_order: assert property (@(posedge pclk) disable iff (!rst_n)
        (!lvds_en_reg || vdd_en_reg) && (!video_en_reg || lvds_en_reg) && (!bl_en_reg || video_en_reg));

endmodule

// File: tb/tb_lvds_panel_seq.sv
// Directed bench for lvds_panel_seq: a timestamp-based model checked every cycle,
// plus literal expectations for the key edges of each scenario.
module tb_lvds_panel_seq;

    localparam int T_VDD     = 4;
    localparam int T_CLK     = 3;
    localparam int T_BL_ON   = 5;
    localparam int T_BL_OFF  = 2;
    localparam int T_VDD_OFF = 3;
    localparam int T_OFF_MIN = 6;
    localparam int VS_TO     = 16;

    logic pclk  = 1'b0;
    logic rst_n = 1'b0;

    lvds_panel_seq_if bus();

    lvds_panel_seq #(
        .T_VDD     (T_VDD),
        .T_CLK     (T_CLK),
        .T_BL_ON   (T_BL_ON),
        .T_BL_OFF  (T_BL_OFF),
        .T_VDD_OFF (T_VDD_OFF),
        .T_OFF_MIN (T_OFF_MIN),
        .VS_TO     (VS_TO),
        .VS_POL    (1'b1),
        .CNT_W     (20)
    ) dut (
        .pclk  (pclk),
        .rst_n (rst_n),
        .ctl   (bus)
    );

    always #5 pclk = ~pclk;

    int errors  = 0;
    int checks  = 0;
    int cyc     = 0;
    int base    = 0;
    int vs_mode = 0;
    int vs_base = 0;

    always @(posedge pclk) cyc <= cyc + 1;

    // vs: mode 1 is a 20-cycle frame with the active pulse in cycles 15..19.
    always @(negedge pclk) begin
        if (vs_mode == 1 && (((cyc - vs_base) % 20) >= 15)) bus.vs = 1'b1;
        else bus.vs = 1'b0;
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Model: absolute edge timestamps instead of countdowns. m_t is the edge the
    // current state was entered on, m_ready the first edge a power-up may happen.
    int m_state, m_t, m_ready, m_e;
    bit m_to, h1, h2, h3;
    int e_n, ns, nt, nr;
    bit nto, seen;

    always @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= 0; m_t <= 0; m_ready <= 0; m_e <= 0; m_to <= 1'b0;
            h1 <= 1'b0; h2 <= 1'b0; h3 <= 1'b0;
        end else begin
            e_n = m_e + 1;
            ns = m_state; nt = m_t; nr = m_ready; nto = m_to;
            seen = h2 && !h3;
            if (bus.fault && m_state != 0) begin
                ns = 0; nr = e_n + T_OFF_MIN;
            end else begin
                case (m_state)
                    0: if (bus.power_req && !bus.fault && e_n >= m_ready) begin
                           ns = 1; nt = e_n; nto = 1'b0;
                       end
                    1: if (!bus.power_req) begin ns = 0; nr = e_n + T_OFF_MIN; end
                       else if (e_n == m_t + T_VDD) begin ns = 2; nt = e_n; end
                    2: if (!bus.power_req) begin ns = 6; nt = e_n; end
                       else if (e_n >= m_t + T_CLK && (seen || e_n == m_t + T_CLK + VS_TO)) begin
                           ns = 3; nt = e_n; if (!seen) nto = 1'b1;
                       end
                    3: if (!bus.power_req) begin ns = 5; nt = e_n; end
                       else if (e_n == m_t + T_BL_ON) begin ns = 4; nt = e_n; end
                    4: if (!bus.power_req) begin ns = 5; nt = e_n; end
                    5: if (e_n >= m_t + T_BL_OFF && (seen || e_n == m_t + T_BL_OFF + VS_TO)) begin
                           ns = 6; nt = e_n; if (!seen) nto = 1'b1;
                       end
                    6: if (e_n == m_t + T_VDD_OFF) begin ns = 0; nr = e_n + T_OFF_MIN; end
                    default: ns = 0;
                endcase
            end
            m_state <= ns; m_t <= nt; m_ready <= nr; m_to <= nto; m_e <= e_n;
            h1 <= bus.vs; h2 <= h1; h3 <= h2;
        end
    end

    always @(negedge pclk) begin
        if (rst_n) begin
            check("cmp_state",    int'(bus.state),    m_state);
            check("cmp_vdd_en",   int'(bus.vdd_en),   (m_state >= 1 && m_state <= 6) ? 1 : 0);
            check("cmp_lvds_en",  int'(bus.lvds_en),  (m_state >= 2 && m_state <= 5) ? 1 : 0);
            check("cmp_video_en", int'(bus.video_en), (m_state >= 3 && m_state <= 5) ? 1 : 0);
            check("cmp_bl_en",    int'(bus.bl_en),    (m_state == 4) ? 1 : 0);
            check("cmp_ready",    int'(bus.ready),    (m_state == 4) ? 1 : 0);
            check("cmp_vs_tmo",   int'(bus.vs_timeout), int'(m_to));
        end
    end

    function automatic bit sig(input int sel);
        case (sel)
            0:       return bus.vdd_en;
            1:       return bus.lvds_en;
            2:       return bus.video_en;
            3:       return bus.bl_en;
            default: return bus.ready;
        endcase
    endfunction

    // Waits for output 'sel' to reach 'level'; rel is cycles since base, -1 on timeout.
    task automatic wait_lvl(input int sel, input bit level, input int max_cyc, input string name,
                            output int rel, output bit saw_vid);
        rel = -1;
        saw_vid = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge pclk);
            if (bus.video_en || bus.bl_en) saw_vid = 1'b1;
            if (sig(sel) == level) begin
                rel = cyc - base;
                break;
            end
        end
        if (rel < 0) begin
            checks++;
            errors++;
            $display("FAIL %s: level %0d not reached within %0d cycles", name, level, max_cyc);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rel;
        bit saw, saw_any;
        bus.power_req = 1'b0;
        bus.fault     = 1'b0;
        rst_n         = 1'b0;
        repeat (3) @(negedge pclk);
        check("rst_state",  int'(bus.state), 0);
        check("rst_vdd_en", int'(bus.vdd_en), 0);
        check("rst_vs_tmo", int'(bus.vs_timeout), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge pclk);

        // Power-up with vs frames running.
        base = cyc; vs_base = cyc; vs_mode = 1; bus.power_req = 1'b1;
        wait_lvl(0, 1'b1, 10, "up_vdd", rel, saw);   check("up_vdd_at", rel, 1);
        wait_lvl(1, 1'b1, 10, "up_lvds", rel, saw);  check("up_lvds_at", rel, 5);
        wait_lvl(2, 1'b1, 30, "up_video", rel, saw); check("up_video_at", rel, 18);
        wait_lvl(3, 1'b1, 10, "up_bl", rel, saw);    check("up_bl_at", rel, 23);
        check("up_ready", int'(bus.ready), 1);
        check("up_state", int'(bus.state), 4);
        $display("txn power-up complete at cycle %0d", cyc);

        // Power-down from ON, video stop aligned to the vs edge at frame cycle 35.
        while (cyc < base + 30) @(negedge pclk);
        base = cyc; bus.power_req = 1'b0;
        wait_lvl(3, 1'b0, 5, "dn_bl", rel, saw);     check("dn_bl_at", rel, 1);
        wait_lvl(2, 1'b0, 30, "dn_video", rel, saw); check("dn_video_at", rel, 8);
        check("dn_lvds_with_video", int'(bus.lvds_en), 0);
        check("dn_vdd_still_on", int'(bus.vdd_en), 1);
        wait_lvl(0, 1'b0, 10, "dn_vdd", rel, saw);   check("dn_vdd_at", rel, 11);
        check("dn_state", int'(bus.state), 0);
        $display("txn power-down complete at cycle %0d", cyc);

        // Immediate re-request must respect the minimum off time.
        base = cyc; bus.power_req = 1'b1;
        wait_lvl(0, 1'b1, 20, "reup_vdd", rel, saw); check("reup_vdd_at", rel, 6);
        wait_lvl(1, 1'b1, 10, "reup_lvds", rel, saw); check("reup_lvds_at", rel, 10);
        $display("txn off-time re-request complete at cycle %0d", cyc);

        // Abort while in CLK.
        base = cyc; bus.power_req = 1'b0;
        wait_lvl(1, 1'b0, 5, "abort_lvds", rel, saw_any); check("abort_lvds_at", rel, 1);
        wait_lvl(0, 1'b0, 10, "abort_vdd", rel, saw);     check("abort_vdd_at", rel, 4);
        check("abort_no_video", int'(saw_any | saw), 0);
        $display("txn clk-abort complete at cycle %0d", cyc);

        // vs tied low: both vs waits run to the timeout.
        vs_mode = 0;
        repeat (10) @(negedge pclk);
        base = cyc; bus.power_req = 1'b1;
        wait_lvl(2, 1'b1, 40, "tmo_video", rel, saw); check("tmo_video_at", rel, 24);
        check("tmo_flag_set", int'(bus.vs_timeout), 1);
        wait_lvl(4, 1'b1, 10, "tmo_ready", rel, saw); check("tmo_ready_at", rel, 29);
        base = cyc; bus.power_req = 1'b0;
        wait_lvl(0, 1'b0, 40, "tmo_dn_vdd", rel, saw); check("tmo_dn_vdd_at", rel, 22);
        repeat (8) @(negedge pclk);
        check("tmo_flag_sticky", int'(bus.vs_timeout), 1);
        base = cyc; bus.power_req = 1'b1;
        wait_lvl(0, 1'b1, 10, "tmo_reup", rel, saw); check("tmo_reup_at", rel, 1);
        check("tmo_flag_cleared", int'(bus.vs_timeout), 0);
        $display("txn vs-timeout complete at cycle %0d", cyc);

        // Fault in ON.
        wait_lvl(4, 1'b1, 60, "flt_ready", rel, saw);
        bus.fault = 1'b1;
        @(negedge pclk);
        check("flt_vdd",   int'(bus.vdd_en), 0);
        check("flt_lvds",  int'(bus.lvds_en), 0);
        check("flt_video", int'(bus.video_en), 0);
        check("flt_bl",    int'(bus.bl_en), 0);
        check("flt_state", int'(bus.state), 0);
        repeat (3) @(negedge pclk);
        check("flt_blocks_up", int'(bus.vdd_en), 0);
        bus.fault = 1'b0;
        $display("txn fault complete at cycle %0d", cyc);

        // Asynchronous reset mid-VID, between clock edges.
        base = cyc;
        wait_lvl(2, 1'b1, 60, "rst_video", rel, saw);
        #2 rst_n = 1'b0;
        #1;
        check("arst_vdd",   int'(bus.vdd_en), 0);
        check("arst_lvds",  int'(bus.lvds_en), 0);
        check("arst_video", int'(bus.video_en), 0);
        check("arst_state", int'(bus.state), 0);
        check("arst_tmo",   int'(bus.vs_timeout), 0);
        @(negedge pclk);
        bus.power_req = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge pclk);
        $display("txn async-reset complete at cycle %0d", cyc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
